// File: rtl/ro_sched_pkg.sv
// Shared types and helpers for the ring-oscillator measurement scheduler.
// Declarations only: no logic, no latency, no flow control.
package ro_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_GATE   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_PUSH   = 3'd5,
        ST_DONE   = 3'd6
    } ro_sched_state_e;

    // Channel index width; a single-channel bank still needs one select bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx[4:0];
    endfunction

endpackage

// File: rtl/ro_chan_pick.sv
// Combinational priority picker: lowest enabled channel at or above ptr.
// Zero latency; no flow control.
module ro_chan_pick #(
    parameter int NUM_RO = 8,
    parameter int CH_W   = 3
) (
    input  logic [NUM_RO-1:0] mask,
    input  logic [CH_W:0]     ptr,
    output logic              found,
    output logic [CH_W-1:0]   idx
);

    // Descending walk so the last hit written is the lowest qualifying index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_RO - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                idx   = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/ro_meas_sched.sv
// Time-shares one edge counter across the RO bank: settle, gate, drain, hand off one result per channel.
// Per channel: settle+window+SYNC_LAT+2 cycles; a stalled res_ready holds the whole sweep in PUSH.
module ro_meas_sched
    import ro_sched_pkg::*;
#(
    parameter int NUM_RO   = 8,
    parameter int CNT_W    = 24,
    parameter int WIN_W    = 20,
    parameter int SET_W    = 8,
    parameter int SYNC_LAT = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      cfg_start,
    input  logic                      cfg_abort,
    input  logic                      cfg_continuous,
    input  logic [NUM_RO-1:0]         cfg_mask,
    input  logic [WIN_W-1:0]          cfg_window,
    input  logic [SET_W-1:0]          cfg_settle,
    output logic [NUM_RO-1:0]         ro_en,
    output logic [$clog2(NUM_RO)-1:0] ro_sel,
    output logic                      cnt_clr,
    output logic                      cnt_gate,
    input  logic [CNT_W-1:0]          cnt_value,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [$clog2(NUM_RO)-1:0] res_ch,
    output logic [CNT_W-1:0]          res_count,
    output logic                      res_sat,
    output logic                      busy,
    output logic                      done
);

    localparam int CH_W  = ch_w(NUM_RO);
    localparam int PTR_W = CH_W + 1;
    localparam int DR_W  = (SYNC_LAT > 0) ? $clog2(SYNC_LAT + 1) : 1;

    ro_sched_state_e   state;
    logic [NUM_RO-1:0] mask_q;
    logic [WIN_W-1:0]  window_q;
    logic [SET_W-1:0]  settle_q;
    logic [PTR_W-1:0]  ptr;
    logic [SET_W-1:0]  set_tmr;
    logic [WIN_W-1:0]  win_tmr;
    logic [DR_W-1:0]   drn_tmr;
    logic              pick_found;
    logic [CH_W-1:0]   pick_idx;

    ro_chan_pick #(
        .NUM_RO (NUM_RO),
        .CH_W   (CH_W)
    ) u_pick (
        .mask  (mask_q),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_IDLE;
            mask_q    <= '0;
            window_q  <= '0;
            settle_q  <= '0;
            ptr       <= '0;
            set_tmr   <= '0;
            win_tmr   <= '0;
            drn_tmr   <= '0;
            ro_en     <= '0;
            ro_sel    <= '0;
            cnt_clr   <= 1'b0;
            cnt_gate  <= 1'b0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_count <= '0;
            res_sat   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (cfg_abort && state != ST_IDLE) begin
            // Abort beats handshakes and timer expiry; pending result is dropped.
            state     <= ST_IDLE;
            ro_en     <= '0;
            cnt_clr   <= 1'b0;
            cnt_gate  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        mask_q   <= cfg_mask;
                        window_q <= (cfg_window == '0) ? WIN_W'(1) : cfg_window;
                        settle_q <= (cfg_settle == '0) ? SET_W'(1) : cfg_settle;
                        ptr      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (pick_found) begin
                        ro_sel  <= pick_idx;
                        ro_en   <= NUM_RO'(onehot(32'(pick_idx)));
                        cnt_clr <= 1'b1;
                        set_tmr <= settle_q;
                        state   <= ST_SETTLE;
                    end else begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_SETTLE: begin
                    if (set_tmr <= SET_W'(1)) begin
                        cnt_clr  <= 1'b0;
                        cnt_gate <= 1'b1;
                        win_tmr  <= window_q;
                        state    <= ST_GATE;
                    end else begin
                        set_tmr <= set_tmr - SET_W'(1);
                    end
                end
                ST_GATE: begin
                    if (win_tmr <= WIN_W'(1)) begin
                        cnt_gate <= 1'b0;
                        drn_tmr  <= DR_W'(SYNC_LAT);
                        state    <= ST_DRAIN;
                    end else begin
                        win_tmr <= win_tmr - WIN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Count has crossed domains by the last drain cycle.
                    if (drn_tmr <= DR_W'(1)) begin
                        res_count <= cnt_value;
                        res_ch    <= ro_sel;
                        res_sat   <= &cnt_value;
                        res_valid <= 1'b1;
                        ro_en     <= '0;
                        state     <= ST_PUSH;
                    end else begin
                        drn_tmr <= drn_tmr - DR_W'(1);
                    end
                end
                ST_PUSH: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= PTR_W'(res_ch) + PTR_W'(1);
                        state     <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    if (cfg_continuous) begin
                        ptr   <= '0;
                        state <= ST_SCAN;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ro_en    <= '0;
                    cnt_clr  <= 1'b0;
                    cnt_gate <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ro_meas_sched.md
Name: ro_meas_sched

Overview:
- Measurement scheduler for the ring-oscillator reliability sensor array.
- Time-shares one edge counter among NUM_RO ring oscillators. Per enabled channel it:
  - enables the oscillator,
  - clears the counter and waits a settle time,
  - opens a gate window of exact length,
  - waits for the count to cross into ACLK,
  - hands the result out over a valid/ready port.
- Sits between the AXI4-Lite register slave (config and results) and the RO bank and counter.

Parameters:
NUM_RO, 8, number of ring oscillators (2..32)
CNT_W, 24, counter/result width
WIN_W, 20, gate-window length width (ACLK cycles)
SET_W, 8, settle-time width (ACLK cycles)
SYNC_LAT, 4, cycles from cnt_gate fall until cnt_value is stable in ACLK domain

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
cfg_start  in  1  start pulse; sampled only in IDLE
cfg_abort  in  1  abort request; honoured in any state
cfg_continuous  in  1  repeat sweeps; sampled at each sweep end
cfg_mask  in  NUM_RO  channel enable mask, latched at start
cfg_window  in  WIN_W  gate length, latched at start; 0 treated as 1
cfg_settle  in  SET_W  settle length, latched at start; 0 treated as 1
ro_en  out  NUM_RO  one-hot oscillator enable
ro_sel  out  $clog2(NUM_RO)  counter input mux select
cnt_clr  out  1  synchronous clear to shared counter
cnt_gate  out  1  counter count-enable window
cnt_value  in  CNT_W  synchronized counter value
res_valid  out  1  result available
res_ready  in  1  result accepted
res_ch  out  $clog2(NUM_RO)  channel of result
res_count  out  CNT_W  captured count
res_sat  out  1  captured count == all ones
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of each sweep

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ptr=0.
  - All outputs 0: ro_en, ro_sel, cnt_clr, cnt_gate, res_*, busy, done.
- FSM states: IDLE, SCAN, SETTLE, GATE, DRAIN, PUSH, DONE.
- IDLE:
  - cfg_start=1 latches mask/window/settle, ptr<=0, then goes to SCAN.
  - cfg_start outside IDLE is ignored.
- SCAN (1 cycle): pick the lowest enabled index >= ptr.
  - If found: ro_sel<=idx, ro_en<=onehot(idx), load settle timer, go to SETTLE.
  - If none: go to DONE.
  - Empty mask therefore produces done 2 cycles after start, with no results.
- SETTLE:
  - ro_en and cnt_clr high for exactly max(settle,1) cycles, then go to GATE.
- GATE:
  - cnt_gate high for exactly max(window,1) cycles; cnt_clr low.
  - ro_en held high; then go to DRAIN.
- DRAIN:
  - cnt_gate low, ro_en held high, for SYNC_LAT cycles.
  - On the last cycle: res_count<=cnt_value, res_ch<=ro_sel, res_sat<=&cnt_value. Then go to PUSH.
- PUSH:
  - ro_en=0, res_valid=1. res_* stay stable until res_valid&&res_ready.
  - On that handshake: res_valid<=0, ptr<=res_ch+1, go to SCAN.
  - Backpressure stalls the sweep indefinitely.
  - ptr==NUM_RO after the last channel makes SCAN find none.
- DONE (1 cycle):
  - done=1.
  - If cfg_continuous=1: ptr<=0, go to SCAN with the same latched config.
  - Otherwise go to IDLE.
- Abort:
  - cfg_abort=1 in any non-IDLE state forces IDLE next cycle.
  - ro_en, cnt_gate, cnt_clr, res_valid drop to 0 that edge. A pending result is discarded and done is not pulsed.
  - Abort takes priority over a simultaneous handshake or timer expiry.
- Timers are down-counters sized WIN_W/SET_W/$clog2(SYNC_LAT+1); they never wrap.
- ro_en is never multi-hot. cnt_gate and cnt_clr are never high in the same cycle.

Decomposition:
- Package ro_sched_pkg:
  - state enum ro_sched_state_e
  - CH_W = $clog2(NUM_RO) helper function
  - onehot helper function
- Sub-module ro_chan_pick: combinational priority picker (mask, ptr) -> found, idx. It is instanced once in ro_meas_sched.

Test Plan:
- Reset mid-GATE (assert ARESETN=0 while cnt_gate=1) -> every output 0 asynchronously; state IDLE after release.
- mask=8'b0000_0101, settle=3, window=10, SYNC_LAT=4, res_ready tied 1, cnt_value model counts gate cycles ×7:
  - results ch0 then ch2, each count=70, res_sat=0.
  - cnt_gate exactly 10 cycles per channel; cnt_clr exactly 3 cycles.
  - done pulses once; busy falls the cycle after done.
- Same config, res_ready held 0 for 20 cycles on the first result -> res_valid/res_ch/res_count stable for 20 cycles; ro_en=0 during the stall; ch2 starts only after the handshake.
- mask=0 -> done pulses exactly 2 cycles after cfg_start, res_valid never asserts. window=0, settle=0 on mask=8'h80 -> gate and clear each exactly 1 cycle, res_ch=7.
- cfg_abort during DRAIN of ch1 -> next cycle IDLE, all enables 0, no res_valid, no done. Then cfg_start with mask=8'h02 -> ch1 result delivered normally.
- cfg_continuous=1, mask=8'h81, cnt_value forced 24'hFFFFFF:
  - results ch0, ch7, ch0, ch7… all with res_sat=1, done between sweeps.
  - Clearing cfg_continuous before the second done -> IDLE after that sweep.
